// File: rtl/cpu_pkg.sv
// cpu_pkg: core opcodes and branch-tracking record shared across the pipeline
package cpu_pkg;
  localparam logic [4:0] OP_ADD    = 5'd0;
  localparam logic [4:0] OP_SUB    = 5'd1;
  localparam logic [4:0] OP_AND    = 5'd2;
  localparam logic [4:0] OP_OR     = 5'd3;
  localparam logic [4:0] OP_XOR    = 5'd4;
  localparam logic [4:0] OP_SLL    = 5'd5;
  localparam logic [4:0] OP_SRL    = 5'd6;
  localparam logic [4:0] OP_SRA    = 5'd7;
  localparam logic [4:0] OP_SLT    = 5'd8;
  localparam logic [4:0] OP_SLTU   = 5'd9;
  localparam logic [4:0] OP_ADDI   = 5'd10;
  localparam logic [4:0] OP_ANDI   = 5'd11;
  localparam logic [4:0] OP_ORI    = 5'd12;
  localparam logic [4:0] OP_XORI   = 5'd13;
  localparam logic [4:0] OP_SLLI   = 5'd14;
  localparam logic [4:0] OP_SRLI   = 5'd15;
  localparam logic [4:0] OP_SRAI   = 5'd16;
  localparam logic [4:0] OP_SLTI   = 5'd17;
  localparam logic [4:0] OP_LUI    = 5'd18;
  localparam logic [4:0] OP_LW     = 5'd19;
  localparam logic [4:0] OP_SW     = 5'd20;
  localparam logic [4:0] OP_LB     = 5'd21;
  localparam logic [4:0] OP_SB     = 5'd22;
  localparam logic [4:0] OP_BT     = 5'd23;
  localparam logic [4:0] OP_BF     = 5'd24;
  localparam logic [4:0] OP_JAL    = 5'd25;
  localparam logic [4:0] OP_JALR   = 5'd26;
  localparam logic [4:0] OP_EBREAK = 5'd27;
  localparam int BP_IDX_MAX = 16;
  typedef struct packed {
    logic                  valid;
    logic                  cond;
    logic                  pred_taken;
    logic [BP_IDX_MAX-1:0] idx;
  } bp_track_t;
endpackage

// File: rtl/branch_predictor_bht_sat_counter.sv
// sat_counter: up/down counter that sticks at 0 and all-ones, reset to weakly-low midpoint
module sat_counter #(
  parameter int W = 2
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         en,
  input  logic         inc,
  output logic [W-1:0] q
);
  localparam logic [W-1:0] INIT = W'((1 << (W - 1)) - 1);
  logic sat;
  assign sat = inc ? &q : ~|q;
  always_ff @(posedge clk or negedge reset)
    if (!reset) q <= INIT;
    else if (en && !sat) q <= inc ? q + W'(1) : q - W'(1);
endmodule

// File: rtl/branch_predictor_bht.sv
// branch_predictor_bht: PC-indexed saturating-counter predictor with D/E tracking and resolution
// Optional BP_GSHARE_EN: XOR a non-speculative global history into the table index.
module branch_predictor_bht
  import cpu_pkg::*;
#(
  parameter int PC_W    = 13,
  parameter int OFF_W   = 17,
  parameter int ENTRIES = 64,
  parameter int CTR_W   = 2,
  parameter int CNT_W   = 16
`ifdef BP_GSHARE_EN
  , parameter int HIST_W = $clog2(ENTRIES)
`endif
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             stall,
  input  logic             halted,
  input  logic [PC_W-1:0]  fetch_pc,
  input  logic [4:0]       fetch_opcode,
  input  logic [OFF_W-1:0] fetch_offset,
  input  logic             ex_taken,
  output logic [OFF_W-1:0] predicted_offset,
  output logic [OFF_W-1:0] not_predicted_offset,
  output logic             guess_wrong,
  output logic [CNT_W-1:0] mispredict_count
);
  localparam int IDX_W = $clog2(ENTRIES);
  logic [CTR_W-1:0] ctr [ENTRIES];
  logic [IDX_W-1:0] idx;
  logic             is_cond, is_jal, taken, train;
  bp_track_t        d, e, f;
  logic             unused;
  assign unused = ^{fetch_pc[PC_W-1:IDX_W], e.idx[BP_IDX_MAX-1:IDX_W]};
`ifdef BP_GSHARE_EN
  logic [HIST_W-1:0] ghr;
  assign idx = fetch_pc[IDX_W-1:0] ^ IDX_W'(ghr);
  always_ff @(posedge clk or negedge reset)
    if (!reset) ghr <= '0;
    else if (train) ghr <= HIST_W'({ghr, ex_taken});
`else
  assign idx = fetch_pc[IDX_W-1:0];
`endif
  assign is_cond = fetch_opcode == OP_BT || fetch_opcode == OP_BF;
  assign is_jal  = fetch_opcode == OP_JAL;
  assign taken   = ctr[idx][CTR_W-1];
  assign predicted_offset     = (is_cond && taken) || is_jal ? fetch_offset : OFF_W'(1);
  assign not_predicted_offset = is_cond && !taken ? fetch_offset : OFF_W'(1);
  assign f = '{valid: 1'b1, cond: is_cond, pred_taken: is_cond && taken, idx: BP_IDX_MAX'(idx)};
  assign guess_wrong = e.valid && e.cond && (ex_taken != e.pred_taken) && !halted;
  assign train       = e.valid && e.cond && !halted;
  always_ff @(posedge clk or negedge reset)
    if (!reset) begin
      d <= '0;
      e <= '0;
    end else if (!halted) begin
      d <= guess_wrong ? '0 : stall ? d : f;
      e <= guess_wrong || stall ? '0 : d;
    end
  always_ff @(posedge clk or negedge reset)
    if (!reset) mispredict_count <= '0;
    else if (guess_wrong && !(&mispredict_count)) mispredict_count <= mispredict_count + CNT_W'(1);
  for (genvar i = 0; i < ENTRIES; i++) begin : g_ctr
    sat_counter #(.W(CTR_W)) u_ctr (
      .clk(clk),
      .reset(reset),
      .en(train && e.idx[IDX_W-1:0] == IDX_W'(i)),
      .inc(ex_taken),
      .q(ctr[i])
    );
  end
endmodule

// File: tb/tb_branch_predictor_bht.sv
// tb_branch_predictor_bht: directed table and sequence checks for the bimodal predictor
module tb_branch_predictor_bht;
  import cpu_pkg::*;
  localparam int PC_W = 13, OFF_W = 17, CNT_W = 16;
  logic clk = 0, reset = 0, stall = 0, halted = 0, ex_taken = 0;
  logic [PC_W-1:0]  fetch_pc = '0;
  logic [4:0]       fetch_opcode = '0;
  logic [OFF_W-1:0] fetch_offset = '0;
  logic [OFF_W-1:0] predicted_offset, not_predicted_offset;
  logic             guess_wrong;
  logic [CNT_W-1:0] mispredict_count;
  int checks = 0, errors = 0;
  typedef struct {
    logic [4:0]       op;
    int               pc;
    logic [OFF_W-1:0] off, ep, enp;
  } vec_t;
  vec_t vt [7];
  always #5 clk = ~clk;
  branch_predictor_bht dut (
    .clk(clk), .reset(reset), .stall(stall), .halted(halted),
    .fetch_pc(fetch_pc), .fetch_opcode(fetch_opcode), .fetch_offset(fetch_offset),
    .ex_taken(ex_taken), .predicted_offset(predicted_offset),
    .not_predicted_offset(not_predicted_offset), .guess_wrong(guess_wrong),
    .mispredict_count(mispredict_count)
  );
  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask
  task automatic step;
    @(posedge clk);
    #1;
  endtask
  task automatic fetch(input logic [4:0] op, input int pc, input logic [OFF_W-1:0] off);
    fetch_opcode = op;
    fetch_pc     = PC_W'(pc);
    fetch_offset = off;
  endtask
  task automatic nop;
    fetch(OP_ADD, 0, '0);
  endtask
  task automatic run_branch(input string name, input logic [4:0] op, input int pc,
                            input logic [OFF_W-1:0] off, input logic tk,
                            input logic [OFF_W-1:0] ep, input logic [OFF_W-1:0] enp,
                            input logic egw);
    fetch(op, pc, off);
    ex_taken = 0;
    #1;
    chk({name, "_pred"}, 32'(predicted_offset), 32'(ep));
    chk({name, "_npred"}, 32'(not_predicted_offset), 32'(enp));
    step;
    nop;
    step;
    ex_taken = tk;
    #1;
    chk({name, "_gw"}, 32'(guess_wrong), 32'(egw));
    step;
    ex_taken = 0;
  endtask
  initial begin
    int bad;
    vt[0] = '{OP_BT,  0,  17'd8,       17'd1,       17'd8};
    vt[1] = '{OP_BF,  3,  17'h1FFF0,   17'd1,       17'h1FFF0};
    vt[2] = '{OP_JAL, 10, 17'h1FFFC,   17'h1FFFC,   17'd1};
    vt[3] = '{OP_ADD, 5,  17'd8,       17'd1,       17'd1};
    vt[4] = '{OP_SB,  5,  17'd8,       17'd1,       17'd1};
    vt[5] = '{OP_JALR, 5, 17'd8,       17'd1,       17'd1};
    vt[6] = '{OP_BT,  69, 17'd8,       17'd1,       17'd8};
    halted = 1;
    step;
    step;
    chk("rst_count", 32'(mispredict_count), 0);
    chk("rst_gw", 32'(guess_wrong), 0);
    chk("rst_ctr5", 32'(dut.ctr[5]), 1);
    reset = 1;
    step;
    for (int i = 0; i < 7; i++) begin
      fetch(vt[i].op, vt[i].pc, vt[i].off);
      #1;
      chk($sformatf("vec%0d_pred", i), 32'(predicted_offset), 32'(vt[i].ep));
      chk($sformatf("vec%0d_npred", i), 32'(not_predicted_offset), 32'(vt[i].enp));
      chk($sformatf("vec%0d_gw", i), 32'(guess_wrong), 0);
      step;
    end
    halted = 0;
    nop;
    step;
    run_branch("bt1", OP_BT, 5, 17'd8, 1, 17'd1, 17'd8, 1);
    #1;
    chk("bt1_ctr", 32'(dut.ctr[5]), 2);
    chk("bt1_cnt", 32'(mispredict_count), 1);
    chk("bt1_gw_clr", 32'(guess_wrong), 0);
    run_branch("bt2", OP_BT, 5, 17'd8, 1, 17'd8, 17'd1, 0);
    chk("bt2_ctr", 32'(dut.ctr[5]), 3);
    run_branch("bt3", OP_BT, 5, 17'd8, 1, 17'd8, 17'd1, 0);
    chk("bt3_ctr_sat", 32'(dut.ctr[5]), 3);
    chk("bt3_cnt", 32'(mispredict_count), 1);
    run_branch("jal", OP_JAL, 10, 17'h1FFFC, 1, 17'h1FFFC, 17'd1, 0);
    chk("jal_ctr", 32'(dut.ctr[10]), 1);
    chk("jal_cnt", 32'(mispredict_count), 1);
    fetch(OP_BF, 7, 17'd12);
    step;
    nop;
    stall = 1;
    ex_taken = 1;
    for (int i = 0; i < 3; i++) begin
      #1;
      chk($sformatf("stall%0d_gw", i), 32'(guess_wrong), 0);
      step;
    end
    chk("stall_ctr_held", 32'(dut.ctr[7]), 1);
    stall = 0;
    step;
    chk("stall_res_gw", 32'(guess_wrong), 1);
    step;
    ex_taken = 0;
    chk("stall_ctr", 32'(dut.ctr[7]), 2);
    chk("stall_cnt", 32'(mispredict_count), 2);
    step;
    chk("stall_once", 32'(dut.ctr[7]), 2);
    fetch(OP_BT, 5, 17'd8);
    step;
    fetch(OP_BT, 12, 17'd4);
    step;
    nop;
    #1;
    chk("flush_gw", 32'(guess_wrong), 1);
    step;
    ex_taken = 1;
    chk("flush_gw_d0", 32'(guess_wrong), 0);
    step;
    chk("flush_gw_d1", 32'(guess_wrong), 0);
    step;
    ex_taken = 0;
    chk("flush_ctr12", 32'(dut.ctr[12]), 1);
    chk("flush_ctr5", 32'(dut.ctr[5]), 2);
    chk("flush_cnt", 32'(mispredict_count), 3);
    fetch(OP_BT, 20, 17'd8);
    step;
    nop;
    step;
    halted = 1;
    ex_taken = 1;
    #1;
    chk("halt_gw", 32'(guess_wrong), 0);
    step;
    step;
    chk("halt_ctr", 32'(dut.ctr[20]), 1);
    chk("halt_cnt", 32'(mispredict_count), 3);
    halted = 0;
    #1;
    chk("unhalt_gw", 32'(guess_wrong), 1);
    reset = 0;
    #1;
    chk("arst_gw", 32'(guess_wrong), 0);
    chk("arst_cnt", 32'(mispredict_count), 0);
    bad = 0;
    for (int i = 0; i < 64; i++) if (dut.ctr[i] !== 2'd1) bad++;
    chk("arst_ctrs", 32'(bad), 0);
    ex_taken = 0;
    step;
    reset = 1;
    step;
    run_branch("nt1", OP_BT, 5, 17'd8, 0, 17'd1, 17'd8, 0);
    chk("nt1_ctr", 32'(dut.ctr[5]), 0);
    run_branch("nt2", OP_BF, 5, 17'd8, 0, 17'd1, 17'd8, 0);
    chk("nt2_ctr_sat", 32'(dut.ctr[5]), 0);
    chk("nt_cnt", 32'(mispredict_count), 0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
